iex_muldiv_unit: RTL and testbench
==================================

Name: iex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage.
- Consumes the operands and instruction fields registered by the Decode→Execute pipeline register, after forwarding muxes.
- Holds the pipeline through a stall output while it runs. Its result goes into the Execute result mux ahead of the Execute→Memory register.
- One shared shift/add-subtract datapath serves all eight M-extension ops.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  a valid M-type instruction is in Execute (opcode 0110011, funct7 0000001); must stay high until done.
funct3E  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
SrcAE  input  XLEN  rs1 value (forwarded).
SrcBE  input  XLEN  rs2 value (forwarded).
StallMD  output  1  combinational: start & ~done; freezes PC, IF/ID and ID/IEx, and bubbles IEx/IM.
done  output  1  registered; high exactly one cycle when ResultMD is valid.
ResultMD  output  XLEN  registered result; holds until the next op captures.
busy  output  1  registered; high in CALC and FIXUP.

Behaviour:
- Reset (async, any state): FSM→IDLE; done, busy, ResultMD, counter and all internal registers → 0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: if start, capture operands, funct3 and operand signs at the edge.
  - Signed operands for MULH/DIV/REM. rs1 only for MULHSU. None for MULHU/DIVU/REMU.
  - Store magnitudes. Counter → 0.
  - Special case → DONE with result preloaded, skipping CALC:
    - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → SrcAE.
    - signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Otherwise → CALC.
- CALC: one iteration per cycle, counter 0..31; → FIXUP after the counter=31 cycle.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract with 32-bit remainder and quotient registers.
- FIXUP: one cycle.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; remainder takes the dividend's sign.
  - Select low or high word (MUL low; MULH/MULHSU/MULHU high), quotient or remainder.
  - Write ResultMD; → DONE.
- DONE: done=1 for one cycle; → IDLE unconditionally, even if start is still high. This prevents re-issuing the same instruction.
- Latency: start first high in cycle c0.
  - Normal op: CALC c1–c32, FIXUP c33, done in c34; StallMD high c0–c33.
  - Special case: done in c1; StallMD high c0 only.
- Back-to-back M ops: the next instruction's start is seen in IDLE in c35 (c2 after a special case) and starts a new op.
- Abort (flush): start low in CALC or FIXUP → IDLE next edge. done is not asserted and ResultMD is unchanged.
- Operand inputs are ignored after capture; changes mid-op have no effect.
- start in DONE has no effect. start low in IDLE holds state.
- Arithmetic is modulo 2^32 except the 64-bit product; no exceptions are raised.

Test Plan:
- Reset mid-CALC (assert at c20) → in the same cycle done=0, busy=0, ResultMD=0, FSM IDLE; a new MUL afterwards completes normally.
- MUL 7 × 0xFFFFFFFD → done at c34, ResultMD=0xFFFFFFEB. StallMD high c0–c33, low in c34. MULHU same operands → 0x00000006.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; all with done at c34.
- DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; each with done at c1 and StallMD high for one cycle only.
- Abort: start dropped at c10 of a DIV → IDLE at c11, done never pulses, ResultMD keeps its prior value. Two back-to-back MULs with start held high → two distinct done pulses, 35 cycles apart, correct results.

Source files
------------

// File: rtl/iex_muldiv_unit.sv
// iex_muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage.
// Ports: clk/reset (async, active-high); start, funct3E, SrcAE, SrcBE from Decode->Execute;
// StallMD freezes the front end while running; done pulses one cycle with ResultMD valid;
// busy is high while iterating (CALC) or fixing up signs (FIXUP).
module iex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallMD,
  output logic            done,
  output logic [XLEN-1:0] ResultMD,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  localparam logic [XLEN-1:0]  MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic              sa, sb;
  logic [XLEN-1:0]   bm;
  // hi half: product high word or partial remainder; lo half: multiplier or dividend/quotient
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   hi, lo, am, bmag, spec_res, fix_res;
  logic              sgn_a, sgn_b, div0, ovf, special, is_div, ok;
  logic [XLEN:0]     x, y;
  logic [XLEN+1:0]   s;
  logic [2*XLEN-1:0] step, prod;
  assign StallMD = start & ~done;
  assign hi      = acc[2*XLEN-1:XLEN];
  assign lo      = acc[XLEN-1:0];
  assign is_div  = f3[2];
  always_comb begin
    sgn_a    = SrcAE[XLEN-1] & (funct3E inside {3'b001, 3'b010, 3'b100, 3'b110});
    sgn_b    = SrcBE[XLEN-1] & (funct3E inside {3'b001, 3'b100, 3'b110});
    am       = sgn_a ? -SrcAE : SrcAE;
    bmag     = sgn_b ? -SrcBE : SrcBE;
    div0     = funct3E[2] & ~|SrcBE;
    ovf      = funct3E[2] & ~funct3E[0] & (SrcAE == MIN) & (&SrcBE);
    special  = div0 | ovf;
    spec_res = div0 ? (funct3E[1] ? SrcAE : '1) : (funct3E[1] ? '0 : MIN);
    // one adder: multiply adds the multiplicand, divide subtracts the divisor (x + ~b + 1)
    x        = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
    y        = is_div ? ~{1'b0, bm} : (lo[0] ? {1'b0, bm} : '0);
    s        = {1'b0, x} + {1'b0, y} + (XLEN+2)'(is_div);
    ok       = s[XLEN+1];
    step     = is_div ? {ok ? s[XLEN-1:0] : x[XLEN-1:0], lo[XLEN-2:0], ok} : {s[XLEN:0], lo[XLEN-1:1]};
    prod     = (sa ^ sb) ? -acc : acc;
    fix_res  = is_div ? (f3[1] ? (sa ? -hi : hi) : ((sa ^ sb) ? -lo : lo))
                      : (|f3[1:0] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start ? (special ? DONE : CALC) : IDLE;
      CALC:    nxt = ~start ? IDLE : (cnt == LAST ? FIXUP : CALC);
      FIXUP:   nxt = start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      busy     <= 1'b0;
      ResultMD <= '0;
      cnt      <= '0;
      f3       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      bm       <= '0;
      acc      <= '0;
    end else begin
      state <= nxt;
      done  <= nxt == DONE;
      busy  <= nxt == CALC || nxt == FIXUP;
      if (state == IDLE && start) begin
        f3  <= funct3E;
        sa  <= sgn_a;
        sb  <= sgn_b;
        bm  <= bmag;
        acc <= {{XLEN{1'b0}}, am};
        cnt <= '0;
        if (special) ResultMD <= spec_res;
      end else if (state == CALC && start) begin
        acc <= step;
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIXUP && start) begin
        ResultMD <= fix_res;
      end
    end
  end
endmodule

// File: tb/tb_iex_muldiv_unit.sv
// tb_iex_muldiv_unit: scoreboard bench for iex_muldiv_unit with directed RV32M vectors.
module tb_iex_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic        StallMD, done, busy;
  logic [31:0] ResultMD;
  int cyc = 0, npass = 0, ntot = 0, ndone = 0;
  typedef struct {logic [31:0] val; int at;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  iex_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3E(funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .StallMD(StallMD), .done(done), .ResultMD(ResultMD), .busy(busy)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      ndone++;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        x = q.pop_front();
        chk("result", ResultMD, x.val);
        chk("done_cycle", cyc, x.at);
      end
    end
  end
  task automatic op(input string n, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] e, input int lat, input bit hold);
    int st = 0;
    bit seen = 0;
    @(negedge clk);
    funct3E = f; SrcAE = a; SrcBE = b; start = 1'b1;
    q.push_back('{e, cyc + lat});
    for (int i = 0; i < 80 && !seen; i++) begin
      #1;
      if (done) seen = 1;
      else begin
        st += int'(StallMD);
        @(negedge clk);
      end
    end
    if (!seen) chk({n, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({n, "_stall_cycles"}, st, lat);
      chk({n, "_stall_at_done"}, {31'd0, StallMD}, 32'd0);
    end
    if (!hold) start = 1'b0;
  endtask
  initial begin
    int n0, d1, d2;
    repeat (2) @(negedge clk);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_result", ResultMD, 0);
    chk("rst_stall", {31'd0, StallMD}, 0);
    reset = 1'b0;
    op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    op("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
    op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
    op("mul",    3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    op("mulhu",  3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 34, 0);
    op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, 0);
    op("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0);
    op("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 0);
    op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
    op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    @(negedge clk);
    funct3E = 3'b100; SrcAE = 32'd100; SrcBE = 32'd7; start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    #1 chk("abort_busy_c10", {31'd0, busy}, 1);
    n0 = ndone;
    @(negedge clk);
    #1 chk("abort_busy_c11", {31'd0, busy}, 0);
    chk("abort_stall_c11", {31'd0, StallMD}, 0);
    repeat (40) @(negedge clk);
    chk("abort_result_kept", ResultMD, 32'd2);
    chk("abort_no_done", ndone, n0);
    op("mul_b2b1", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1);
    d1 = cyc;
    op("mul_b2b2", 3'b000, 32'h12345, 32'h100, 32'h01234500, 34, 0);
    d2 = cyc;
    chk("b2b_gap", d2 - d1, 35);
    @(negedge clk);
    funct3E = 3'b000; SrcAE = 32'h11; SrcBE = 32'h11; start = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk("pre_reset_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1 chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_result", ResultMD, 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    op("mul_after_reset", 3'b000, 32'h11, 32'h11, 32'h121, 34, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("done_count", ndone, 15);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
